// File: rtl/toy_dmem_responder.sv
// rtl/toy_dmem_responder.sv - single-port data-memory responder with IO registers
//
// Purpose: services one CPU data-port request at a time. A request is captured
// in IDLE, optionally waits WAIT_STATES cycles, and completes on the RESP edge,
// after which ack pulses for one cycle. Addresses 0x000..0xFFD hit a 4094-word
// RAM, 0xFFE is the io_out register and 0xFFF reads io_in (writes discarded).
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - asynchronous active-low reset
//   rd_dmem  - read request strobe
//   wr_dmem  - write request strobe
//   adr      - 12-bit word address
//   wdata    - 16-bit write data
//   io_in    - external input port, read at 0xFFF
//   rdata    - registered read data, updated only by completed reads
//   ack      - one-cycle completion pulse
//   busy     - request captured and not yet acknowledged
//   io_out   - external output port register, written at 0xFFE
//   err      - sticky flag: read and write strobes seen together at capture
module toy_dmem_responder #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_dmem,
    input  logic        wr_dmem,
    input  logic [11:0] adr,
    input  logic [15:0] wdata,
    input  logic [15:0] io_in,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic [15:0] io_out,
    output logic        err
);
    localparam logic [11:0] ADR_IO_OUT = 12'hFFE;
    localparam logic [11:0] ADR_IO_IN  = 12'hFFF;
    localparam bit          HAS_WAIT   = (WAIT_STATES != 0);
    // Final count value in WAIT; unused when WAIT_STATES is 0.
    localparam logic [1:0]  WAIT_LAST  = 2'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [11:0] adr_q, adr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [15:0] io_out_q, io_out_d;
    logic        err_q, err_d;
    logic        capture, resp, do_rd, do_wr, mem_we;

    logic [15:0] mem [0:4093];

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            adr_q    <= 12'd0;
            wdata_q  <= 16'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rdata_q  <= 16'd0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            io_out_q <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            io_out_q <= io_out_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rd_dmem || wr_dmem) state_d = HAS_WAIT ? S_WAIT : S_RESP;
            S_WAIT: if (cnt_q == WAIT_LAST) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values.
    always_comb begin
        capture  = (state_q == S_IDLE) && (rd_dmem || wr_dmem);
        resp     = (state_q == S_RESP);
        // A conflicting rd+wr request is acknowledged but performs no access.
        do_rd    = resp && rd_q && !wr_q;
        do_wr    = resp && wr_q && !rd_q;
        mem_we   = do_wr && (adr_q < ADR_IO_OUT);

        cnt_d    = (state_q == S_WAIT) ? cnt_q + 2'd1 : 2'd0;
        adr_d    = capture ? adr     : adr_q;
        wdata_d  = capture ? wdata   : wdata_q;
        rd_d     = capture ? rd_dmem : rd_q;
        wr_d     = capture ? wr_dmem : wr_q;

        busy_d   = busy_q;
        if (capture)   busy_d = 1'b1;
        else if (resp) busy_d = 1'b0;
        ack_d    = resp;
        err_d    = err_q || (capture && rd_dmem && wr_dmem);

        io_out_d = (do_wr && (adr_q == ADR_IO_OUT)) ? wdata_q : io_out_q;

        rdata_d  = rdata_q;
        if (do_rd) begin
            if (adr_q == ADR_IO_OUT)     rdata_d = io_out_q;
            else if (adr_q == ADR_IO_IN) rdata_d = io_in;
            else                         rdata_d = mem[adr_q];
        end
    end

    // RAM contents survive reset; reset forces IDLE, so mem_we drops at once.
    always_ff @(posedge clk) begin
        if (mem_we) mem[adr_q] <= wdata_q;
    end

    assign rdata  = rdata_q;
    assign ack    = ack_q;
    assign busy   = busy_q;
    assign io_out = io_out_q;
    assign err    = err_q;

endmodule

// File: tb/tb_toy_dmem_responder.sv
// tb/tb_toy_dmem_responder.sv - randomized self-checking bench for toy_dmem_responder
module tb_toy_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [3];
    logic        rd_dmem [3];
    logic        wr_dmem [3];
    logic [11:0] adr     [3];
    logic [15:0] wdata   [3];
    logic [15:0] io_in   [3];
    logic [15:0] rdata   [3];
    logic        ack     [3];
    logic        busy    [3];
    logic [15:0] io_out  [3];
    logic        err     [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        toy_dmem_responder #(
            .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : 3)
        ) u_dut (
            .clk     (clk),
            .reset   (rst_n[g]),
            .rd_dmem (rd_dmem[g]),
            .wr_dmem (wr_dmem[g]),
            .adr     (adr[g]),
            .wdata   (wdata[g]),
            .io_in   (io_in[g]),
            .rdata   (rdata[g]),
            .ack     (ack[g]),
            .busy    (busy[g]),
            .io_out  (io_out[g]),
            .err     (err[g])
        );
    end

    // Reference model: architectural state per instance.
    logic [15:0] m_mem   [3][4096];
    bit          m_vld   [3][4096];
    logic [15:0] m_io    [3];
    logic [15:0] m_rd    [3];
    bit          m_rdk   [3];
    bit          m_err   [3];

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_io[k]  = 16'h0000;
        m_rd[k]  = 16'h0000;
        m_rdk[k] = 1'b1;
        m_err[k] = 1'b0;
    endtask

    task automatic model_apply(input int k, input bit rd, input bit wr, input logic [11:0] a,
                               input logic [15:0] d, input logic [15:0] io);
        if (rd && wr) begin
            m_err[k] = 1'b1;
        end else if (wr) begin
            if (a == 12'hFFE) m_io[k] = d;
            else if (a != 12'hFFF) begin
                m_mem[k][a] = d;
                m_vld[k][a] = 1'b1;
            end
        end else if (rd) begin
            if (a == 12'hFFE) begin
                m_rd[k] = m_io[k]; m_rdk[k] = 1'b1;
            end else if (a == 12'hFFF) begin
                m_rd[k] = io; m_rdk[k] = 1'b1;
            end else begin
                m_rd[k] = m_mem[k][a]; m_rdk[k] = m_vld[k][a];
            end
        end
    endtask

    task automatic check_idle_outputs(input int k, input string tag);
        check({tag, "_ack"},    ack[k],    1'b0);
        check({tag, "_busy"},   busy[k],   1'b0);
        check({tag, "_rdata"},  rdata[k],  16'h0000);
        check({tag, "_io_out"}, io_out[k], 16'h0000);
        check({tag, "_err"},    err[k],    1'b0);
    endtask

    // One request: drive, capture, wait for ack, compare against model.
    task automatic xact(input int k, input bit rd, input bit wr, input logic [11:0] a,
                        input logic [15:0] d, input logic [15:0] io, input bit toggle);
        int lat;
        bit seen;
        rd_dmem[k] = rd; wr_dmem[k] = wr; adr[k] = a; wdata[k] = d; io_in[k] = io;
        @(posedge clk); #1;
        check("busy_on_capture", busy[k], 1'b1);
        check("ack_low_after_capture", ack[k], 1'b0);
        // Captured address/data must be used, so scramble the live inputs.
        adr[k] = a ^ 12'h0F3; wdata[k] = ~d;
        if (toggle) begin
            rd_dmem[k] = 1'b0; wr_dmem[k] = 1'b1;
        end else begin
            rd_dmem[k] = 1'b0; wr_dmem[k] = 1'b0;
        end
        lat = 0; seen = 1'b0;
        while (!seen && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (ack[k]) seen = 1'b1;
            else check("busy_while_pending", busy[k], 1'b1);
            if (lat == 1) begin rd_dmem[k] = 1'b0; wr_dmem[k] = 1'b0; end
        end
        check("ack_seen", seen, 1'b1);
        check("ack_latency", lat, ws_of(k) + 1);
        if (seen) begin
            model_apply(k, rd, wr, a, d, io);
            check("busy_in_ack", busy[k], 1'b0);
            if (m_rdk[k]) check("rdata", rdata[k], m_rd[k]);
            check("io_out", io_out[k], m_io[k]);
            check("err", err[k], m_err[k]);
        end
    endtask

    task automatic reset_inst(input int k);
        rst_n[k] = 1'b0;
        #2;
        model_reset(k);
        check_idle_outputs(k, "reset");
        @(posedge clk); #1;
        rst_n[k] = 1'b1;
        @(posedge clk); #1;
        check("post_reset_ack", ack[k], 1'b0);
        check("post_reset_busy", busy[k], 1'b0);
    endtask

    initial begin
        logic [11:0] a;
        logic [15:0] d;
        int r, sel;
        bit rd, wr, tg;

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; rd_dmem[k] = 1'b0; wr_dmem[k] = 1'b0;
            adr[k] = 12'd0; wdata[k] = 16'd0; io_in[k] = 16'd0;
            model_reset(k);
            for (int i = 0; i < 4096; i++) m_vld[k][i] = 1'b0;
        end
        #12;
        for (int k = 0; k < 3; k++) check_idle_outputs(k, "init");
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

        // WAIT_STATES=1: write then read back.
        xact(1, 0, 1, 12'h010, 16'hBEEF, 16'h0000, 0);
        xact(1, 1, 0, 12'h010, 16'h0000, 16'h0000, 0);
        check("read_beef", rdata[1], 16'hBEEF);

        // WAIT_STATES=0: io_out, io_in paths, discarded write to 0xFFF.
        xact(0, 0, 1, 12'hFFE, 16'h1234, 16'h0000, 0);
        check("io_out_1234", io_out[0], 16'h1234);
        xact(0, 1, 0, 12'hFFE, 16'h0000, 16'h0000, 0);
        check("read_ffe", rdata[0], 16'h1234);
        xact(0, 1, 0, 12'hFFF, 16'h0000, 16'h5A5A, 0);
        check("read_ffi", rdata[0], 16'h5A5A);
        xact(0, 0, 1, 12'h000, 16'h7777, 16'h0000, 0);
        xact(0, 0, 1, 12'hFFF, 16'h0001, 16'h0000, 0);
        check("io_out_kept", io_out[0], 16'h1234);
        xact(0, 1, 0, 12'h000, 16'h0000, 16'h0000, 0);
        check("read_7777", rdata[0], 16'h7777);

        // Conflicting strobes: acked, err sticky, no access.
        xact(1, 0, 1, 12'h020, 16'h00AA, 16'h0000, 0);
        xact(1, 1, 1, 12'h020, 16'h5555, 16'h0000, 0);
        check("err_set", err[1], 1'b1);
        xact(1, 1, 0, 12'h020, 16'h0000, 16'h0000, 0);
        check("read_00aa", rdata[1], 16'h00AA);
        check("err_sticky", err[1], 1'b1);
        reset_inst(1);

        // WAIT_STATES=3: reset during WAIT discards the write.
        xact(2, 0, 1, 12'hFFE, 16'h9999, 16'h0000, 0);
        xact(2, 0, 1, 12'h005, 16'h1111, 16'h0000, 0);
        rd_dmem[2] = 1'b0; wr_dmem[2] = 1'b1; adr[2] = 12'h005; wdata[2] = 16'hCAFE;
        @(posedge clk); #1;
        rd_dmem[2] = 1'b0; wr_dmem[2] = 1'b0;
        @(posedge clk); #1;
        check("busy_in_wait", busy[2], 1'b1);
        rst_n[2] = 1'b0;
        #1;
        model_reset(2);
        check_idle_outputs(2, "midreset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midreset_no_ack", ack[2], 1'b0);
        end
        rst_n[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("after_reset_no_ack", ack[2], 1'b0);
            check("after_reset_idle", busy[2], 1'b0);
        end
        xact(2, 1, 0, 12'h005, 16'h0000, 16'h0000, 0);
        check("read_1111", rdata[2], 16'h1111);

        // Strobe moved to another address during WAIT: ignored.
        xact(2, 0, 1, 12'h006, 16'h4242, 16'h0000, 1);
        @(posedge clk); #1;
        check("single_ack", ack[2], 1'b0);
        xact(2, 1, 0, 12'h006 ^ 12'h0F3, 16'h0000, 16'h0000, 0);
        xact(2, 1, 0, 12'h006, 16'h0000, 16'h0000, 0);
        check("read_4242", rdata[2], 16'h4242);

        // Randomized mix; back-to-back whenever no idle cycle is inserted.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40; i++) begin
                sel = $urandom_range(0, 9);
                if (sel <= 5)      a = 12'($urandom_range(0, 7));
                else if (sel == 6) a = 12'hFFD;
                else if (sel == 7) a = 12'hFFE;
                else if (sel == 8) a = 12'hFFF;
                else               a = 12'($urandom_range(0, 4093));
                r = $urandom_range(0, 15);
                rd = (r >= 7);
                wr = (r < 7) || (r == 15);
                d  = 16'($urandom);
                tg = (ws_of(k) > 0) && ($urandom_range(0, 3) == 0);
                xact(k, rd, wr, a, d, 16'($urandom), tg);
                if ($urandom_range(0, 2) == 0) begin
                    @(posedge clk); #1;
                    check("rand_ack_pulse", ack[k], 1'b0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
